// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-to-read bypass and a per-register busy scoreboard.
// Optional build macro REGFILE_INIT_INDEX_EN: reset loads register i with value i.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*AW-1:0]     wreg,
  input  logic [NUM_WR*XLEN-1:0]   wdata,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_reg,
  input  logic [NUM_RD*AW-1:0]     reg_rd,
  output logic [NUM_RD*XLEN-1:0]   out_data,
  output logic [NUM_RD-1:0]        out_ready,
  output logic [NREGS-1:0]         busy_vec
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_val;
  logic            w_hit;

  // Ascending port order with non-blocking updates lets the highest port win a conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
`ifdef REGFILE_INIT_INDEX_EN
        r_regs[i] <= (i == 0) ? '0 : XLEN'(i);
`else
        r_regs[i] <= '0;
`endif
      end
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] && wreg[p*AW +: AW] != '0)
          r_regs[wreg[p*AW +: AW]] <= wdata[p*XLEN +: XLEN];
      end
    end
  end

  // Set is applied after the clears so a new producer supersedes a retiring one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] && wreg[p*AW +: AW] != '0)
          r_busy[wreg[p*AW +: AW]] <= 1'b0;
      end
      if (issue_valid && issue_reg != '0)
        r_busy[issue_reg] <= 1'b1;
    end
  end

  always_comb begin
    out_data  = '0;
    out_ready = '0;
    w_idx     = '0;
    w_val     = '0;
    w_hit     = 1'b0;
    for (int r = 0; r < NUM_RD; r++) begin
      w_idx = reg_rd[r*AW +: AW];
      w_val = r_regs[w_idx];
      w_hit = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] && wreg[p*AW +: AW] == w_idx && w_idx != '0) begin
          w_val = wdata[p*XLEN +: XLEN];
          w_hit = 1'b1;
        end
      end
      if (w_idx == '0)
        w_val = '0;
      out_data[r*XLEN +: XLEN] = w_val;
      out_ready[r]             = !r_busy[w_idx] || w_hit;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: stimulus pushes model predictions, a negedge monitor compares.
module tb_regfile_scoreboard;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_WR-1:0]      we;
  logic [NUM_WR*AW-1:0]   wreg;
  logic [NUM_WR*XLEN-1:0] wdata;
  logic                   issue_valid;
  logic [AW-1:0]          issue_reg;
  logic [NUM_RD*AW-1:0]   reg_rd;
  logic [NUM_RD*XLEN-1:0] out_data;
  logic [NUM_RD-1:0]      out_ready;
  logic [NREGS-1:0]       busy_vec;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk(clk), .reset(reset), .we(we), .wreg(wreg), .wdata(wdata),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .reg_rd(reg_rd),
    .out_data(out_data), .out_ready(out_ready), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_RD*XLEN-1:0] data;
    logic [NUM_RD-1:0]      rdy;
    logic [NREGS-1:0]       busy;
    string                  tag;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Architectural view: register contents and pending flags, updated once per clock edge.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin
`ifdef REGFILE_INIT_INDEX_EN
      m_regs[i] = XLEN'(i);
`else
      m_regs[i] = '0;
`endif
      m_busy[i] = 1'b0;
    end
    m_regs[0] = '0;
  endfunction

  function automatic exp_t model_expect(input string tag);
    exp_t e;
    e.tag = tag;
    for (int r = 0; r < NUM_RD; r++) begin
      int idx;
      logic [XLEN-1:0] v;
      bit hit;
      idx = int'(reg_rd[r*AW +: AW]);
      v   = (idx == 0) ? '0 : m_regs[idx];
      hit = 1'b0;
      for (int p = 0; p < NUM_WR; p++)
        if (we[p] && int'(wreg[p*AW +: AW]) == idx && idx != 0) begin
          v   = wdata[p*XLEN +: XLEN];
          hit = 1'b1;
        end
      e.data[r*XLEN +: XLEN] = v;
      e.rdy[r] = (idx == 0) || !m_busy[idx] || hit;
    end
    for (int i = 0; i < NREGS; i++) e.busy[i] = m_busy[i];
    return e;
  endfunction

  function automatic void model_step();
    for (int p = 0; p < NUM_WR; p++) begin
      int w;
      w = int'(wreg[p*AW +: AW]);
      if (we[p] && w != 0) begin
        m_regs[w] = wdata[p*XLEN +: XLEN];
        m_busy[w] = 1'b0;
      end
    end
    if (issue_valid && issue_reg != 0) m_busy[issue_reg] = 1'b1;
  endfunction

  task automatic cyc(input logic [1:0] w_en, input int w0, input logic [XLEN-1:0] d0,
                     input int w1, input logic [XLEN-1:0] d1, input bit iv, input int ir,
                     input int r0, input int r1, input string tag);
    @(posedge clk);
    #1;
    we          = w_en;
    wreg        = {AW'(w1), AW'(w0)};
    wdata       = {d1, d0};
    issue_valid = iv;
    issue_reg   = AW'(ir);
    reg_rd      = {AW'(r1), AW'(r0)};
    q.push_back(model_expect(tag));
    model_step();
  endtask

  task automatic idle(input int r0, input int r1, input string tag);
    cyc(2'b00, 0, '0, 0, '0, 1'b0, 0, r0, r1, tag);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (out_data !== e.data) begin
        n_fail++;
        $display("FAIL %s data got=%h want=%h", e.tag, out_data, e.data);
      end
      n_checks++;
      if (out_ready !== e.rdy) begin
        n_fail++;
        $display("FAIL %s ready got=%b want=%b", e.tag, out_ready, e.rdy);
      end
      n_checks++;
      if (busy_vec !== e.busy) begin
        n_fail++;
        $display("FAIL %s busy got=%h want=%h", e.tag, busy_vec, e.busy);
      end
    end
  end

  initial begin
    reset = 1'b0;
    we = '0; wreg = '0; wdata = '0; issue_valid = 1'b0; issue_reg = '0;
    reg_rd = {AW'(5), AW'(3)};
    model_reset();
    #1;
    q.push_back(model_expect("reset_read"));
    @(posedge clk);
    #3 reset = 1'b1;

    cyc(2'b01, 7, 32'hDEADBEEF, 0, '0, 1'b0, 0, 7, 7, "bypass_x7");
    idle(7, 0, "array_x7");

    cyc(2'b01, 0, 32'h1234, 0, '0, 1'b1, 0, 0, 0, "x0_write_issue");
    idle(0, 0, "x0_after");

    cyc(2'b00, 0, '0, 0, '0, 1'b1, 9, 9, 1, "issue_x9");
    idle(9, 9, "x9_busy");
    cyc(2'b01, 9, 32'h55, 0, '0, 1'b0, 0, 9, 0, "x9_wb_bypass");
    idle(9, 0, "x9_cleared");

    cyc(2'b11, 4, 32'h11, 4, 32'h22, 1'b1, 4, 4, 4, "x4_conflict");
    idle(4, 4, "x4_after");

    cyc(2'b01, 12, 32'hAB, 0, '0, 1'b1, 12, 12, 0, "x12_write_issue");
    idle(12, 12, "x12_busy");

    @(posedge clk);
    #1;
    we = '0; issue_valid = 1'b0; reg_rd = {AW'(12), AW'(4)};
    #2 reset = 1'b0;
    model_reset();
    q.push_back(model_expect("async_reset"));
    @(posedge clk);
    #3 reset = 1'b1;

    for (int k = 0; k < 400; k++) begin
      cyc(2'($urandom_range(0, 3)),
          int'($urandom_range(0, 15)), $urandom,
          int'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "random");
    end
    idle(1, 2, "final_idle");

    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
